// File: rtl/mod_ram_arbiter_pkg.sv
// Shared definitions for the two-requester asynchronous-SRAM arbiter:
// FSM encoding, default widths, owner encoding and the round-robin pick rule.
package mod_ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // With both requesting, the requester not served last wins.
  function automatic logic rr_pick(input logic req_a, input logic req_b,
                                   input logic last_owner);
    logic pick;
    if (req_a && req_b) begin
      pick = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
    end else if (req_b) begin
      pick = OWNER_B;
    end else begin
      pick = OWNER_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod_rr_arbiter2.sv
// Two-way round-robin grant selection; purely combinational, the caller
// decides when the grant is taken.
module mod_rr_arbiter2
  import mod_ram_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_owner,
  output logic grant_valid,
  output logic grantee
);

  // Grant decode
  always_comb begin
    grant_valid = req_a | req_b;
    grantee     = rr_pick(req_a, req_b, last_owner);
  end

endmodule

// File: rtl/mod_ram_arbiter.sv
// Arbitrates a single asynchronous SRAM between a loader (A) and a hash core (B)
// using a fixed four-phase access: IDLE, SETUP, STROBE, RECOVER.
module mod_ram_arbiter
  import mod_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              RAM_CE_N,
  output logic              RAM_WE_N,
  output logic              RAM_OE_N,
  output logic              BUSY,
  output logic              OWNER,
  output logic [15:0]       XFER_CNT
);

  logic [1:0] state;
  logic       lat_we;
  logic       grant_valid;
  logic       grantee;

  mod_rr_arbiter2 u_rr (
    .req_a       (A_REQ),
    .req_b       (B_REQ),
    .last_owner  (OWNER),
    .grant_valid (grant_valid),
    .grantee     (grantee)
  );

  // Access sequencer; RAM_ADDR/RAM_WDATA double as the request latch so they
  // stay stable from SETUP through RECOVER and hold afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
      RAM_CE_N  <= 1'b1;
      RAM_WE_N  <= 1'b1;
      RAM_OE_N  <= 1'b1;
      A_ACK     <= 1'b0;
      B_ACK     <= 1'b0;
      A_RDATA   <= '0;
      B_RDATA   <= '0;
      BUSY      <= 1'b0;
      OWNER     <= OWNER_B;
      XFER_CNT  <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state <= ST_SETUP;
            BUSY  <= 1'b1;
            OWNER <= grantee;
            if (grantee == OWNER_B) begin
              lat_we    <= B_WE;
              RAM_ADDR  <= B_ADDR;
              RAM_WDATA <= B_WDATA;
            end else begin
              lat_we    <= A_WE;
              RAM_ADDR  <= A_ADDR;
              RAM_WDATA <= A_WDATA;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state    <= ST_STROBE;
          RAM_CE_N <= 1'b0;
          RAM_WE_N <= ~lat_we;
          RAM_OE_N <= lat_we;
        end
        ST_STROBE: begin
          state    <= ST_RECOVER;
          RAM_CE_N <= 1'b1;
          RAM_WE_N <= 1'b1;
          RAM_OE_N <= 1'b1;
          XFER_CNT <= XFER_CNT + 16'd1;
          if (OWNER == OWNER_B) begin
            B_ACK <= 1'b1;
            if (!lat_we) begin
              B_RDATA <= RAM_RDATA;
            end
          end else begin
            A_ACK <= 1'b1;
            if (!lat_we) begin
              A_RDATA <= RAM_RDATA;
            end
          end
        end
        ST_RECOVER: begin
          state <= ST_IDLE;
          A_ACK <= 1'b0;
          B_ACK <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          RAM_CE_N <= 1'b1;
          RAM_WE_N <= 1'b1;
          RAM_OE_N <= 1'b1;
          A_ACK    <= 1'b0;
          B_ACK    <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_ram_arbiter.sv
// Randomized self-checking bench for mod_ram_arbiter with an SRAM model and a
// transaction-level reference (expected memory, access count, last grantee).
module tb_mod_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [14:0] a_addr = 15'h0, b_addr = 15'h0;
  logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_ce_n, ram_we_n, ram_oe_n, busy, owner;
  logic [15:0] xfer_cnt;

  logic [31:0] ram     [0:32767];
  logic [31:0] ref_mem [0:32767];
  logic [15:0] ref_cnt = 16'h0;
  logic        ref_last = 1'b1;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [14:0] prev_addr = 15'h0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  mod_ram_arbiter dut (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(a_ack), .A_RDATA(a_rdata),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(b_ack), .B_RDATA(b_rdata),
    .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata),
    .RAM_CE_N(ram_ce_n), .RAM_WE_N(ram_we_n), .RAM_OE_N(ram_oe_n),
    .BUSY(busy), .OWNER(owner), .XFER_CNT(xfer_cnt)
  );

  // Asynchronous SRAM: data out while selected and output-enabled.
  assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? ram[ram_addr] : 32'h0;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) ram[ram_addr] <= ram_wdata;
  end

  // Bus protocol watch, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (a_ack && b_ack) begin
        bad++;
        $display("FAIL proto_ack a_ack=%0b b_ack=%0b required at most one", a_ack, b_ack);
      end
      total++;
      if ((!ram_we_n && !ram_oe_n) || (ram_ce_n && (!ram_we_n || !ram_oe_n))) begin
        bad++;
        $display("FAIL proto_strobe ce_n=%0b we_n=%0b oe_n=%0b", ram_ce_n, ram_we_n, ram_oe_n);
      end
      if (prev_busy && busy) begin
        total++;
        if (ram_addr !== prev_addr) begin
          bad++;
          $display("FAIL proto_addr_stable got=%h required=%h", ram_addr, prev_addr);
        end
      end
    end
    prev_busy <= busy;
    prev_addr <= ram_addr;
  end

  task automatic test_reset;
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 15'h1234; b_addr = 15'h4321; a_wdata = 32'hFFFF_0000; b_wdata = 32'h0000_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({ram_ce_n, ram_we_n, ram_oe_n} !== 3'b111) begin bad++; $display("FAIL rst_strobes got=%b required=111", {ram_ce_n, ram_we_n, ram_oe_n}); end
    total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL rst_acks got=%b required=00", {a_ack, b_ack}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
    total++; if (owner !== 1'b1) begin bad++; $display("FAIL rst_owner got=%b required=1", owner); end
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h required=0000", xfer_cnt); end
    total++; if (ram_addr !== 15'h0 || ram_wdata !== 32'h0) begin bad++; $display("FAIL rst_ram_bus addr=%h wdata=%h required=0", ram_addr, ram_wdata); end
    total++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata a=%h b=%h required=0", a_rdata, b_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    ref_cnt = 16'h0; ref_last = 1'b1; chk_en = 1'b1;
  endtask

  // One single-requester access, with latency and strobe-timing checks.
  task automatic access(input bit who, input bit we, input logic [14:0] addr, input logic [31:0] wdata);
    logic [31:0] prev_rd, got_rd;
    logic        got_owner;
    logic [15:0] got_cnt;
    int          ack_k, we_k, we_lows;
    bit          got;
    ack_k = -1; we_k = -1; we_lows = 0; got = 1'b0;
    got_rd = 32'h0; got_owner = 1'b0; got_cnt = 16'h0;
    @(posedge clk); #1;
    prev_rd = who ? b_rdata : a_rdata;
    if (who) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ram_we_n === 1'b0) begin we_lows++; we_k = k; end
      total++;
      if ((who ? a_ack : b_ack) !== 1'b0) begin bad++; $display("FAIL other_ack k=%0d got=1 required=0", k); end
      if ((who ? b_ack : a_ack) === 1'b1) begin
        got = 1'b1; ack_k = k; got_owner = owner; got_cnt = xfer_cnt;
        got_rd = who ? b_rdata : a_rdata;
      end
      if (k == 1) begin
        if (who) begin b_we = $urandom_range(0, 1); b_addr = 15'($urandom); b_wdata = $urandom; end
        else begin a_we = $urandom_range(0, 1); a_addr = 15'($urandom); a_wdata = $urandom; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    total++; if (ack_k != 3) begin bad++; $display("FAIL ack_latency got=%0d required=3", ack_k); end
    total++; if (we_lows != (we ? 1 : 0) || (we && we_k != 2)) begin bad++; $display("FAIL we_timing lows=%0d at=%0d required=%0d at 2", we_lows, we_k, we ? 1 : 0); end
    if (got) begin
      total++;
      if (got_rd !== (we ? prev_rd : ref_mem[addr])) begin bad++; $display("FAIL rdata addr=%h got=%h required=%h", addr, got_rd, we ? prev_rd : ref_mem[addr]); end
      total++; if (got_owner !== who) begin bad++; $display("FAIL owner got=%b required=%b", got_owner, who); end
      total++; if (got_cnt !== ref_cnt + 16'd1) begin bad++; $display("FAIL xfer_cnt got=%h required=%h", got_cnt, ref_cnt + 16'd1); end
    end
    if (we) ref_mem[addr] = wdata;
    ref_cnt = ref_cnt + 16'd1;
    ref_last = who;
  endtask

  task automatic test_write_read_a;
    access(1'b0, 1'b1, 15'h0005, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 15'h0005, 32'h0);
    total++; if (a_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL a_readback got=%h required=deadbeef", a_rdata); end
    total++; if (xfer_cnt !== 16'd2) begin bad++; $display("FAIL a_cnt got=%h required=0002", xfer_cnt); end
  endtask

  task automatic test_readback_b;
    access(1'b1, 1'b1, 15'h7FFF, 32'h1234_5678);
    access(1'b1, 1'b0, 15'h7FFF, 32'h0);
    total++; if (b_rdata !== 32'h1234_5678) begin bad++; $display("FAIL b_readback got=%h required=12345678", b_rdata); end
  endtask

  task automatic test_contention;
    bit          exp_who, exp_a, exp_b;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0011;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0022;
    exp_who = ~ref_last;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      exp_a = (k % 4 == 3) && !exp_who;
      exp_b = (k % 4 == 3) && exp_who;
      total++;
      if (a_ack !== exp_a || b_ack !== exp_b) begin bad++; $display("FAIL rr_ack k=%0d got=%b%b required=%b%b", k, a_ack, b_ack, exp_a, exp_b); end
      if (k % 4 == 3) begin
        exp_rd = exp_who ? ref_mem[15'h0022] : ref_mem[15'h0011];
        total++;
        if ((exp_who ? b_rdata : a_rdata) !== exp_rd) begin bad++; $display("FAIL rr_rdata k=%0d got=%h required=%h", k, exp_who ? b_rdata : a_rdata, exp_rd); end
        total++; if (owner !== exp_who) begin bad++; $display("FAIL rr_owner k=%0d got=%b required=%b", k, owner, exp_who); end
        ref_cnt = ref_cnt + 16'd1;
        total++; if (xfer_cnt !== ref_cnt) begin bad++; $display("FAIL rr_cnt got=%h required=%h", xfer_cnt, ref_cnt); end
        ref_last = exp_who;
        exp_who = ~exp_who;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic test_reset_in_strobe;
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0100; a_wdata = wd;
    repeat (3) @(negedge clk);
    total++; if (ram_we_n !== 1'b0) begin bad++; $display("FAIL rs_in_strobe we_n got=%b required=0", ram_we_n); end
    rst = 1'b1; a_req = 1'b0;
    @(negedge clk);
    total++; if ({ram_ce_n, ram_we_n, ram_oe_n} !== 3'b111) begin bad++; $display("FAIL rs_strobes got=%b required=111", {ram_ce_n, ram_we_n, ram_oe_n}); end
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rs_cnt got=%h required=0000", xfer_cnt); end
    total++; if (owner !== 1'b1) begin bad++; $display("FAIL rs_owner got=%b required=1", owner); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL rs_no_ack k=%0d got=%b required=00", k, {a_ack, b_ack}); end
    end
    ref_mem[15'h0100] = wd;
    ref_cnt = 16'h0; ref_last = 1'b1;
  endtask

  task automatic test_cnt_wrap;
    @(posedge clk); #1;
    force dut.XFER_CNT = 16'hFFFD;
    #1 release dut.XFER_CNT;
    ref_cnt = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)), $urandom);
    end
    @(negedge clk);
    total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h required=0000", xfer_cnt); end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32768; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    test_reset;
    test_write_read_a;
    test_readback_b;
    test_contention;
    test_random;
    test_reset_in_strobe;
    test_cnt_wrap;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
